cache_mem_bridge: RTL and testbench

Sits between the direct-mapped data cache's 128-bit line port and the 32-bit word-wide external memory. It converts each cache line request (read fill or dirty write-back) into a burst of four single-word handshakes. It then returns a one-cycle `mem_ready` pulse that the cache uses to complete its miss/write-back step. Address and write data are latched when the request is accepted, so the cache-side request only has to remain valid until `mem_ready`.

---
 rtl/cache_mem_bridge.sv | 111 +++++++++++
 tb/tb_cache_mem_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge.sv
// rtl/cache_mem_bridge.sv - 128-bit cache line port to 32-bit external memory burst bridge
// Each line request becomes four word beats; mem_ready pulses once per completed burst.
module cache_mem_bridge #(
  parameter int REQ_GAP = 0
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         ext_req,
  output logic         ext_we,
  output logic [29:0]  ext_addr,
  output logic [31:0]  ext_wdata,
  input  logic [31:0]  ext_rdata,
  input  logic         ext_ack
);

  typedef enum logic [1:0] {IDLE, BEAT, GAP, DONE} state_t;

  localparam logic [2:0] GAP_LAST = 3'(REQ_GAP - 1);

  state_t       state, state_nxt;
  logic [1:0]   beat;
  logic [2:0]   gap_cnt;
  logic         op_we;
  logic [27:0]  line_addr;
  logic [127:0] line_wdata;
  logic [95:0]  rd_buf;
  logic [31:0]  beat_word;

  always_ff @(posedge clk) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_read || mem_write) state_nxt = BEAT;
      BEAT: begin
        if (ext_ack) begin
          if (beat == 2'd3)     state_nxt = DONE;
          else if (REQ_GAP > 0) state_nxt = GAP;
        end
      end
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = BEAT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read words 0..2 are staged in rd_buf so mem_rdata only changes at DONE.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      beat       <= 2'd0;
      gap_cnt    <= 3'd0;
      op_we      <= 1'b0;
      line_addr  <= 28'd0;
      line_wdata <= 128'd0;
      rd_buf     <= 96'd0;
      mem_rdata  <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_we      <= mem_write;
            line_addr  <= mem_addr;
            line_wdata <= mem_wdata;
            beat       <= 2'd0;
          end
        end
        BEAT: begin
          if (ext_ack) begin
            gap_cnt <= 3'd0;
            if (!op_we) begin
              case (beat)
                2'd0:    rd_buf[31:0]  <= ext_rdata;
                2'd1:    rd_buf[63:32] <= ext_rdata;
                2'd2:    rd_buf[95:64] <= ext_rdata;
                default: mem_rdata     <= {ext_rdata, rd_buf};
              endcase
            end
            if (beat != 2'd3) beat <= beat + 2'd1;
          end
        end
        GAP: gap_cnt <= gap_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (beat)
      2'd0:    beat_word = line_wdata[31:0];
      2'd1:    beat_word = line_wdata[63:32];
      2'd2:    beat_word = line_wdata[95:64];
      default: beat_word = line_wdata[127:96];
    endcase
  end

  assign ext_req   = (state == BEAT);
  assign ext_we    = ext_req && op_we;
  assign ext_addr  = ext_req ? {line_addr, beat} : 30'd0;
  assign ext_wdata = ext_req ? beat_word : 32'd0;
  assign mem_ready = (state == DONE);

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb/tb_cache_mem_bridge.sv - scoreboard bench for cache_mem_bridge (REQ_GAP 0 and 2)
module tb_cache_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  beat_t        a_bq[$], b_bq[$];
  logic [127:0] a_lq[$], b_lq[$];
  logic [31:0]  mem [logic [29:0]];

  localparam logic [127:0] WB_LINE  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] B_WLINE  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  logic         a_rst, a_rd, a_wr, a_ready, a_req, a_we, a_ack;
  logic [27:0]  a_maddr;
  logic [127:0] a_mwdata, a_mrdata;
  logic [29:0]  a_eaddr;
  logic [31:0]  a_ewdata, a_erdata;

  logic         b_rst, b_rd, b_wr, b_ready, b_req, b_we, b_ack;
  logic [27:0]  b_maddr;
  logic [127:0] b_mwdata, b_mrdata;
  logic [29:0]  b_eaddr;
  logic [31:0]  b_ewdata, b_erdata;

  cache_mem_bridge #(.REQ_GAP(0)) u_a (
    .clk(clk), .proc_reset(a_rst), .mem_read(a_rd), .mem_write(a_wr),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata), .mem_ready(a_ready),
    .ext_req(a_req), .ext_we(a_we), .ext_addr(a_eaddr), .ext_wdata(a_ewdata),
    .ext_rdata(a_erdata), .ext_ack(a_ack)
  );

  cache_mem_bridge #(.REQ_GAP(2)) u_b (
    .clk(clk), .proc_reset(b_rst), .mem_read(b_rd), .mem_write(b_wr),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata), .mem_ready(b_ready),
    .ext_req(b_req), .ext_we(b_we), .ext_addr(b_eaddr), .ext_wdata(b_ewdata),
    .ext_rdata(b_erdata), .ext_ack(b_ack)
  );

  function automatic logic [31:0] mem_rd(input logic [29:0] ad);
    if (mem.exists(ad)) return mem[ad];
    return 32'hA000_0000 + {2'b00, ad};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory A acks in the same cycle as the request; memory B acks after 3 waits
  // and drives stray acks whenever its request is low.
  assign a_ack = a_req & ~a_rst;
  always @(posedge clk) begin
    #1;
    a_erdata = mem_rd(a_eaddr);
  end

  int b_wait = 0;
  always @(posedge clk) begin
    #1;
    b_erdata = mem_rd(b_eaddr);
    if (b_req) begin
      if (b_wait == 3) begin
        b_ack  = 1'b1;
        b_wait = 0;
      end else begin
        b_ack  = 1'b0;
        b_wait = b_wait + 1;
      end
    end else begin
      b_ack  = 1'b1;
      b_wait = 0;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (a_req && a_ack) begin
      if (a_we) mem[a_eaddr] = a_ewdata;
      if (a_bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_beat_unexpected: got addr %h expected none", a_eaddr);
      end else begin
        e = a_bq.pop_front();
        chk("a_beat_addr", 128'(a_eaddr), 128'(e.addr));
        chk("a_beat_we", 128'(a_we), 128'(e.we));
        if (e.we) chk("a_beat_wdata", 128'(a_ewdata), 128'(e.wdata));
      end
    end
    if (a_ready) begin
      if (a_lq.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_ready_unexpected: got ready at cycle %0d expected none", cyc);
      end else chk("a_line", a_mrdata, a_lq.pop_front());
    end
  end

  int b_acks = 0, b_last_ack = 0, b_low = 0;
  always @(negedge clk) begin
    beat_t e;
    if (b_req && b_ack) begin
      if (b_we) mem[b_eaddr] = b_ewdata;
      if (b_bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_beat_unexpected: got addr %h expected none", b_eaddr);
      end else begin
        e = b_bq.pop_front();
        chk("b_beat_addr", 128'(b_eaddr), 128'(e.addr));
        chk("b_beat_we", 128'(b_we), 128'(e.we));
        if (e.we) chk("b_beat_wdata", 128'(b_ewdata), 128'(e.wdata));
      end
      b_acks++;
      b_last_ack = cyc;
    end
    if (b_req) begin
      if (b_low > 0 && b_acks >= 1 && b_acks <= 3) chk("b_gap_len", 128'(b_low), 128'(2));
      b_low = 0;
    end else b_low++;
    if (b_ready) begin
      chk("b_ready_after_ack", 128'(cyc), 128'(b_last_ack + 1));
      chk("b_acks_per_burst", 128'(b_acks), 128'(4));
      b_acks = 0;
      if (b_lq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_ready_unexpected: got ready at cycle %0d expected none", cyc);
      end else chk("b_line", b_mrdata, b_lq.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input bit sel_b, input logic [29:0] base, input logic we,
                            input logic [127:0] line);
    for (int k = 0; k < 4; k++) begin
      beat_t e;
      e.addr  = base + 30'(k);
      e.we    = we;
      e.wdata = line[32*k +: 32];
      if (sel_b) b_bq.push_back(e);
      else       a_bq.push_back(e);
    end
  endtask

  task automatic wait_ready(input bit sel_b, input string nm);
    int n;
    n = 0;
    while (!(sel_b ? b_ready : a_ready) && n < 200) begin
      tick();
      n++;
    end
    if (!(sel_b ? b_ready : a_ready)) begin
      checks++; errors++;
      $display("FAIL %s: got no mem_ready expected one within 200 cycles", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_maddr = '0; a_mwdata = '0;
    b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_maddr = '0; b_mwdata = '0;
    b_ack = 1'b0; b_erdata = '0; a_erdata = '0;
    repeat (2) tick();
    chk("rst_ready", 128'(a_ready), 128'(0));
    chk("rst_req", 128'(a_req), 128'(0));
    chk("rst_rdata", a_mrdata, 128'(0));
    chk("rst_b_req", 128'(b_req), 128'(0));
    a_rst = 1'b0; b_rst = 1'b0;
    tick();

    // read fill of line 0x10, minimum latency
    a_rd = 1'b1; a_maddr = 28'h10;
    push_beats(0, 30'h40, 1'b0, 128'd0);
    a_lq.push_back(128'hA0000043_A0000042_A0000041_A0000040);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        chk("t1_req", 128'(a_req), 128'(1));
        chk("t1_we", 128'(a_we), 128'(0));
        chk("t1_addr", 128'(a_eaddr), 128'(30'h40 + 30'(c - 1)));
      end
      if (c == 5) a_rd = 1'b0;
      chk("t1_ready", 128'(a_ready), 128'(c == 5));
    end

    // dirty miss: write-back (read+write both high) then fill, inputs disturbed mid-burst
    a_rd = 1'b1; a_wr = 1'b1; a_maddr = 28'h1; a_mwdata = WB_LINE;
    push_beats(0, 30'h4, 1'b1, WB_LINE);
    a_lq.push_back(128'hA0000043_A0000042_A0000041_A0000040);
    push_beats(0, 30'h80, 1'b0, 128'd0);
    a_lq.push_back(128'hA0000083_A0000082_A0000081_A0000080);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) begin a_maddr = 28'h2; a_mwdata = '1; end
      if (c == 5) begin a_wr = 1'b0; a_maddr = 28'h20; end
      if (c == 8) a_maddr = 28'h3;
      if (c == 11) a_rd = 1'b0;
      if (c <= 4) chk("t2_we", 128'(a_we), 128'(1));
      if (c == 6) chk("t2_idle_req", 128'(a_req), 128'(0));
      if (c == 7) begin
        chk("t2_read_req", 128'(a_req), 128'(1));
        chk("t2_read_we", 128'(a_we), 128'(0));
      end
      chk("t2_ready", 128'(a_ready), 128'(c == 5 || c == 11));
    end

    // read back the written line
    a_rd = 1'b1; a_maddr = 28'h1;
    push_beats(0, 30'h4, 1'b0, 128'd0);
    a_lq.push_back(WB_LINE);
    tick();
    wait_ready(0, "t3_ready");
    a_rd = 1'b0;
    tick();

    // reset after the second ack abandons the burst
    a_rd = 1'b1; a_maddr = 28'h5;
    a_bq.push_back(beat_t'{addr: 30'h14, we: 1'b0, wdata: 32'd0});
    a_bq.push_back(beat_t'{addr: 30'h15, we: 1'b0, wdata: 32'd0});
    repeat (3) tick();
    a_rst = 1'b1; a_rd = 1'b0;
    tick();
    chk("t4_ready", 128'(a_ready), 128'(0));
    chk("t4_req", 128'(a_req), 128'(0));
    chk("t4_we", 128'(a_we), 128'(0));
    chk("t4_addr", 128'(a_eaddr), 128'(0));
    chk("t4_wdata", 128'(a_ewdata), 128'(0));
    chk("t4_rdata", a_mrdata, 128'(0));
    a_rst = 1'b0;
    chk("t4_beats_left", 128'(a_bq.size()), 128'(0));
    tick();
    a_rd = 1'b1; a_maddr = 28'h5;
    push_beats(0, 30'h14, 1'b0, 128'd0);
    a_lq.push_back(128'hA0000017_A0000016_A0000015_A0000014);
    tick();
    wait_ready(0, "t4_ready_after");
    a_rd = 1'b0;
    tick();

    // REQ_GAP=2, delayed acks with strays: read, write, read back
    b_rd = 1'b1; b_maddr = 28'h3;
    push_beats(1, 30'hC, 1'b0, 128'd0);
    b_lq.push_back(128'hA000000F_A000000E_A000000D_A000000C);
    tick();
    wait_ready(1, "t5_read_ready");
    b_rd = 1'b0;
    tick();
    b_wr = 1'b1; b_maddr = 28'h7; b_mwdata = B_WLINE;
    push_beats(1, 30'h1C, 1'b1, B_WLINE);
    b_lq.push_back(128'hA000000F_A000000E_A000000D_A000000C);
    tick();
    wait_ready(1, "t5_write_ready");
    b_wr = 1'b0;
    tick();
    b_rd = 1'b1; b_maddr = 28'h7;
    push_beats(1, 30'h1C, 1'b0, 128'd0);
    b_lq.push_back(B_WLINE);
    tick();
    wait_ready(1, "t5_readback_ready");
    b_rd = 1'b0;
    repeat (4) tick();

    chk("end_a_beats", 128'(a_bq.size()), 128'(0));
    chk("end_a_lines", 128'(a_lq.size()), 128'(0));
    chk("end_b_beats", 128'(b_bq.size()), 128'(0));
    chk("end_b_lines", 128'(b_lq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
